// File: rtl/f_fetch_ctrl.sv
// ============================================================================
// f_fetch_ctrl : fetch sequencer (PC, imem request, F/D hand-off, delay slot)
// Optional macro FETCH_ALIGN_CHK_EN: misaligned fetch -> nop with F_adel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_pend_pc;
  logic        r_pend_valid;
  logic        r_adel;

  logic        w_consume;
  logic [31:0] w_next_pc;
  logic [31:0] w_fetch_next;
  logic [31:0] c_reset_fetch;
  logic        w_next_mis;
  logic        w_fetch_mis;

  assign w_consume = (r_state == S_HOLD) && !stall;

  // Redirect in the consume cycle wins; otherwise a parked redirect; else sequential.
  always_comb begin
    w_next_pc = F_pc + 32'd4;
    if (redirect_valid)
      w_next_pc = redirect_pc;
    else if (r_pend_valid)
      w_next_pc = r_pend_pc;
  end

`ifdef FETCH_ALIGN_CHK_EN
  assign w_fetch_next  = w_next_pc;
  assign c_reset_fetch = RESET_PC;
  assign w_next_mis    = |w_next_pc[1:0];
  assign w_fetch_mis   = |r_fetch_addr[1:0];
`else
  // Without the check, low address bits are simply dropped at the source.
  assign w_fetch_next  = w_next_pc & ~32'h3;
  assign c_reset_fetch = RESET_PC & ~32'h3;
  assign w_next_mis    = 1'b0;
  assign w_fetch_mis   = 1'b0;
`endif

  assign imem_req  = (r_state == S_REQ) && !w_fetch_mis;
  assign imem_addr = r_fetch_addr;
  assign F_adel    = r_adel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_REQ;
      r_fetch_addr <= c_reset_fetch;
      r_pend_pc    <= 32'd0;
      r_pend_valid <= 1'b0;
      r_adel       <= 1'b0;
      F_valid      <= 1'b0;
      F_instr      <= 32'd0;
      F_pc         <= c_reset_fetch;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_fetch_mis) begin
            // Only reachable when the reset address itself is misaligned.
            r_state <= S_HOLD;
            F_valid <= 1'b1;
            F_pc    <= r_fetch_addr;
            F_instr <= 32'd0;
            r_adel  <= 1'b1;
          end else if (imem_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state <= S_HOLD;
            F_valid <= 1'b1;
            F_instr <= imem_rdata;
            F_pc    <= r_fetch_addr;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_pend_valid <= 1'b0;
            r_fetch_addr <= w_fetch_next;
            if (w_next_mis) begin
              r_state <= S_HOLD;
              F_valid <= 1'b1;
              F_pc    <= w_fetch_next;
              F_instr <= 32'd0;
              r_adel  <= 1'b1;
            end else begin
              r_state <= S_REQ;
              F_valid <= 1'b0;
              r_adel  <= 1'b0;
            end
          end
        end
        default: r_state <= S_REQ;
      endcase

      // The instruction in F is the delay slot: park the target until it is consumed.
      if (redirect_valid && !w_consume) begin
        r_pend_pc    <= redirect_pc;
        r_pend_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
